// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared FSM state type, forward-source codes and the zero register index
package mips_pipe_pkg;
  typedef enum logic {RUN, MDU_BUSY} state_t;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/mips_fwd_sel.sv
// mips_fwd_sel: compares one source index against a near (MEM-side) and far (WB-side) destination; near wins
//   src/use_src      source index and its read-enable
//   near_dst/near_we nearer producer (reported as FWD_MEM)
//   far_dst/far_we   farther producer (reported as FWD_WB)
//   sel              FWD_REG when nothing matches or src is register zero
module mips_fwd_sel
  import mips_pipe_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  input  logic [REG_W-1:0] near_dst,
  input  logic             near_we,
  input  logic [REG_W-1:0] far_dst,
  input  logic             far_we,
  output logic [1:0]       sel
);
  logic valid;
  assign valid = use_src && src != REG_W'(REG_ZERO);
  assign sel = (valid && near_we && near_dst == src) ? FWD_MEM :
               (valid && far_we && far_dst == src)   ? FWD_WB  : FWD_REG;
endmodule

// File: rtl/mips_hazard_ctrl.sv
// mips_hazard_ctrl: ID/EXE hazard controller issuing stall/bubble/flush, MDU sequencing and a stall-cycle counter
//   clk, rst (async, active-high)
//   id_*  : ID sources and their use flags; exe_*/mem_*/wb_* : downstream destinations and write enables
//   branch_taken : taken branch resolved in EXE
//   pc_write, ifid_write, ifid_flush, idexe_bubble, idexe_hold, exmem_bubble : pipeline controls
//   mdu_busy : multi-cycle MDU op occupying EXE; fwd_a/fwd_b : operand source selects; stall_cnt : saturating
// Build option MIPS_HAZARD_FWD_EN: enables MEM/WB forwarding so only load-use stalls;
// without it any RAW against EXE or MEM stalls and fwd_a/fwd_b stay at the regfile code.
module mips_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int MDU_LAT = 4,
  parameter int SCNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_W-1:0]  exe_rs,
  input  logic [REG_W-1:0]  exe_rt,
  input  logic [REG_W-1:0]  exe_dst,
  input  logic              exe_mem_read,
  input  logic              exe_reg_write,
  input  logic              exe_mdu,
  input  logic [REG_W-1:0]  mem_dst,
  input  logic [REG_W-1:0]  wb_dst,
  input  logic              mem_reg_write,
  input  logic              wb_reg_write,
  input  logic              branch_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idexe_bubble,
  output logic              idexe_hold,
  output logic              exmem_bubble,
  output logic              mdu_busy,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [SCNT_W-1:0] stall_cnt
);
  state_t state, state_nx;
  logic [2:0] mdu_cnt, mdu_cnt_nx;
  logic [1:0] sel_a, sel_b;
  logic load_use, hazard, unused_ok;
  assign load_use = exe_mem_read && exe_dst != REG_W'(REG_ZERO) &&
                    ((id_use_rs && id_rs == exe_dst) || (id_use_rt && id_rt == exe_dst));
`ifdef MIPS_HAZARD_FWD_EN
  mips_fwd_sel #(.REG_W(REG_W)) u_sel_a (
    .src(exe_rs), .use_src(1'b1), .near_dst(mem_dst), .near_we(mem_reg_write),
    .far_dst(wb_dst), .far_we(wb_reg_write), .sel(sel_a)
  );
  mips_fwd_sel #(.REG_W(REG_W)) u_sel_b (
    .src(exe_rt), .use_src(1'b1), .near_dst(mem_dst), .near_we(mem_reg_write),
    .far_dst(wb_dst), .far_we(wb_reg_write), .sel(sel_b)
  );
  assign hazard = load_use;
  assign fwd_a = sel_a;
  assign fwd_b = sel_b;
  assign unused_ok = exe_reg_write;
`else
  // The selectors are reused as RAW detectors: EXE is the near producer, MEM the far one.
  // WB is never a hazard because the register file writes before it reads.
  mips_fwd_sel #(.REG_W(REG_W)) u_sel_a (
    .src(id_rs), .use_src(id_use_rs), .near_dst(exe_dst), .near_we(exe_reg_write),
    .far_dst(mem_dst), .far_we(mem_reg_write), .sel(sel_a)
  );
  mips_fwd_sel #(.REG_W(REG_W)) u_sel_b (
    .src(id_rt), .use_src(id_use_rt), .near_dst(exe_dst), .near_we(exe_reg_write),
    .far_dst(mem_dst), .far_we(mem_reg_write), .sel(sel_b)
  );
  assign hazard = load_use || sel_a != FWD_REG || sel_b != FWD_REG;
  assign fwd_a = FWD_REG;
  assign fwd_b = FWD_REG;
  assign unused_ok = ^{exe_rs, exe_rt, wb_dst, wb_reg_write};
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      mdu_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      mdu_cnt <= mdu_cnt_nx;
      if (!pc_write && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  always_comb begin
    state_nx = state;
    mdu_cnt_nx = mdu_cnt;
    pc_write = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idexe_bubble = 1'b0;
    idexe_hold = 1'b0;
    exmem_bubble = 1'b0;
    if (rst) begin
      pc_write = 1'b0;
      ifid_write = 1'b0;
      idexe_bubble = 1'b1;
    end else if (state == MDU_BUSY) begin
      pc_write = 1'b0;
      ifid_write = 1'b0;
      idexe_hold = 1'b1;
      exmem_bubble = 1'b1;
      mdu_cnt_nx = mdu_cnt != 3'd0 ? mdu_cnt - 3'd1 : 3'd0;
      state_nx = mdu_cnt != 3'd0 ? MDU_BUSY : RUN;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idexe_bubble = 1'b1;
    end else if (exe_mdu) begin
      pc_write = 1'b0;
      ifid_write = 1'b0;
      idexe_hold = 1'b1;
      exmem_bubble = 1'b1;
      mdu_cnt_nx = 3'(MDU_LAT - 2);
      state_nx = MDU_BUSY;
    end else if (hazard) begin
      pc_write = 1'b0;
      ifid_write = 1'b0;
      idexe_bubble = 1'b1;
    end
  end
  assign mdu_busy = state == MDU_BUSY;
endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// tb_mips_hazard_ctrl: directed checks of stall/bubble/flush, MDU sequencing, forwarding and stall counter
module tb_mips_hazard_ctrl;
`ifdef MIPS_HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] id_rs, id_rt, exe_rs, exe_rt, exe_dst, mem_dst, wb_dst;
  logic id_use_rs, id_use_rt, exe_mem_read, exe_reg_write, exe_mdu, mem_reg_write, wb_reg_write, branch_taken;
  logic pc_write, ifid_write, ifid_flush, idexe_bubble, idexe_hold, exmem_bubble, mdu_busy;
  logic [1:0] fwd_a, fwd_b;
  logic [3:0] stall_cnt;
  int total = 0, bad = 0;
  logic [3:0] exp_cnt = 4'd0;

  mips_hazard_ctrl #(.REG_W(5), .MDU_LAT(4), .SCNT_W(4)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .exe_rs(exe_rs), .exe_rt(exe_rt), .exe_dst(exe_dst), .exe_mem_read(exe_mem_read),
    .exe_reg_write(exe_reg_write), .exe_mdu(exe_mdu), .mem_dst(mem_dst), .wb_dst(wb_dst),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write), .branch_taken(branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idexe_bubble(idexe_bubble),
    .idexe_hold(idexe_hold), .exmem_bubble(exmem_bubble), .mdu_busy(mdu_busy),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs;
    {id_rs, id_rt, exe_rs, exe_rt, exe_dst, mem_dst, wb_dst} = '0;
    {id_use_rs, id_use_rt, exe_mem_read, exe_reg_write, exe_mdu, mem_reg_write, wb_reg_write, branch_taken} = '0;
  endtask

  task automatic tick(input bit stalled);
    @(posedge clk);
    #1;
    if (stalled && exp_cnt != 4'hf) exp_cnt = exp_cnt + 4'd1;
    total++;
    if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_reset;
    clear_inputs();
    #1;
    total++;
    if ({pc_write, ifid_write, idexe_bubble} !== 3'b001) begin bad++; $display("FAIL rst_ctrl got=%b exp=001", {pc_write, ifid_write, idexe_bubble}); end
    total++;
    if ({ifid_flush, idexe_hold, exmem_bubble, mdu_busy, fwd_a, fwd_b} !== 8'd0) begin bad++; $display("FAIL rst_other got=%b exp=0", {ifid_flush, idexe_hold, exmem_bubble, mdu_busy, fwd_a, fwd_b}); end
    total++;
    if (stall_cnt !== 4'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", stall_cnt); end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    total++;
    if ({pc_write, ifid_write, idexe_bubble} !== 3'b110) begin bad++; $display("FAIL run_idle got=%b exp=110", {pc_write, ifid_write, idexe_bubble}); end
  endtask

  task automatic test_load_use;
    clear_inputs();
    exe_mem_read = 1; exe_reg_write = 1; exe_dst = 5'd2; id_rs = 5'd2; id_rt = 5'd4; id_use_rs = 1; id_use_rt = 1;
    #1;
    total++;
    if ({pc_write, ifid_write, idexe_bubble, ifid_flush} !== 4'b0010) begin bad++; $display("FAIL lu_ctrl got=%b exp=0010", {pc_write, ifid_write, idexe_bubble, ifid_flush}); end
    tick(1);
    clear_inputs();
    id_rs = 5'd2; id_rt = 5'd4; id_use_rs = 1; id_use_rt = 1; mem_dst = 5'd2; mem_reg_write = 1;
    #1;
    total++;
    if (pc_write !== FWD) begin bad++; $display("FAIL lu_after got=%b exp=%b", pc_write, FWD); end
    tick(!FWD);
    clear_inputs();
    id_rs = 5'd2; id_use_rs = 1; wb_dst = 5'd2; wb_reg_write = 1;
    #1;
    total++;
    if (pc_write !== 1'b1) begin bad++; $display("FAIL lu_wb got=%b exp=1", pc_write); end
    clear_inputs();
    exe_mem_read = 1; exe_dst = 5'd0; id_use_rs = 1;
    #1;
    total++;
    if (pc_write !== 1'b1) begin bad++; $display("FAIL lu_zero got=%b exp=1", pc_write); end
    exe_dst = 5'd7; id_rt = 5'd7; id_use_rt = 0;
    #1;
    total++;
    if (pc_write !== 1'b1) begin bad++; $display("FAIL lu_unused got=%b exp=1", pc_write); end
    tick(0);
  endtask

  task automatic test_branch;
    clear_inputs();
    exe_mem_read = 1; exe_dst = 5'd3; id_rs = 5'd3; id_use_rs = 1; branch_taken = 1; exe_mdu = 1;
    #1;
    total++;
    if ({pc_write, ifid_flush, idexe_bubble, idexe_hold} !== 4'b1110) begin bad++; $display("FAIL br_ctrl got=%b exp=1110", {pc_write, ifid_flush, idexe_bubble, idexe_hold}); end
    tick(0);
    total++;
    if (mdu_busy !== 1'b0) begin bad++; $display("FAIL br_mdu got=%b exp=0", mdu_busy); end
  endtask

  task automatic test_mdu;
    clear_inputs();
    exe_mdu = 1;
    #1;
    total++;
    if ({pc_write, ifid_write, idexe_hold, exmem_bubble, mdu_busy} !== 5'b00110) begin bad++; $display("FAIL mdu_start got=%b exp=00110", {pc_write, ifid_write, idexe_hold, exmem_bubble, mdu_busy}); end
    tick(1);
    exe_mdu = 0; branch_taken = 1; exe_mem_read = 1; exe_dst = 5'd6; id_rs = 5'd6; id_use_rs = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({pc_write, ifid_write, idexe_hold, exmem_bubble, mdu_busy, ifid_flush, idexe_bubble} !== 7'b0011100) begin
        bad++; $display("FAIL mdu_busy%0d got=%b exp=0011100", i, {pc_write, ifid_write, idexe_hold, exmem_bubble, mdu_busy, ifid_flush, idexe_bubble});
      end
      tick(1);
    end
    clear_inputs();
    #1;
    total++;
    if ({pc_write, mdu_busy, idexe_hold} !== 3'b100) begin bad++; $display("FAIL mdu_done got=%b exp=100", {pc_write, mdu_busy, idexe_hold}); end
    tick(0);
  endtask

  task automatic test_raw;
    clear_inputs();
    exe_reg_write = 1; exe_dst = 5'd5; id_rs = 5'd5; id_use_rs = 1;
    #1;
    total++;
    if ({pc_write, idexe_bubble} !== {FWD, !FWD}) begin bad++; $display("FAIL raw_exe got=%b exp=%b", {pc_write, idexe_bubble}, {FWD, !FWD}); end
    tick(!FWD);
    clear_inputs();
    mem_reg_write = 1; mem_dst = 5'd5; id_rt = 5'd5; id_use_rt = 1;
    #1;
    total++;
    if (pc_write !== FWD) begin bad++; $display("FAIL raw_mem got=%b exp=%b", pc_write, FWD); end
    tick(!FWD);
    clear_inputs();
    wb_reg_write = 1; wb_dst = 5'd5; id_rs = 5'd5; id_use_rs = 1;
    #1;
    total++;
    if (pc_write !== 1'b1) begin bad++; $display("FAIL raw_release got=%b exp=1", pc_write); end
    tick(0);
  endtask

  task automatic test_fwd;
    clear_inputs();
    mem_dst = 5'd5; wb_dst = 5'd5; mem_reg_write = 1; wb_reg_write = 1; exe_rs = 5'd5; exe_rt = 5'd0;
    #1;
    total++;
    if (fwd_a !== (FWD ? 2'b01 : 2'b00)) begin bad++; $display("FAIL fwd_mem got=%b exp=%b", fwd_a, FWD ? 2'b01 : 2'b00); end
    total++;
    if (fwd_b !== 2'b00) begin bad++; $display("FAIL fwd_zero got=%b exp=00", fwd_b); end
    mem_reg_write = 0; exe_rt = 5'd5;
    #1;
    total++;
    if ({fwd_a, fwd_b} !== (FWD ? 4'b1010 : 4'b0000)) begin bad++; $display("FAIL fwd_wb got=%b exp=%b", {fwd_a, fwd_b}, FWD ? 4'b1010 : 4'b0000); end
    tick(0);
  endtask

  task automatic test_reset_mid_mdu;
    clear_inputs();
    exe_mdu = 1;
    tick(1);
    exe_mdu = 0;
    tick(1);
    #2 rst = 1'b1;
    #1;
    exp_cnt = 4'd0;
    total++;
    if ({stall_cnt, mdu_busy} !== 5'd0) begin bad++; $display("FAIL rst_mid got=%b exp=0", {stall_cnt, mdu_busy}); end
    #1 rst = 1'b0;
    #1;
    total++;
    if ({pc_write, mdu_busy, idexe_hold} !== 3'b100) begin bad++; $display("FAIL rst_abort got=%b exp=100", {pc_write, mdu_busy, idexe_hold}); end
    tick(0);
  endtask

  task automatic test_saturate;
    clear_inputs();
    exe_mem_read = 1; exe_dst = 5'd9; id_rt = 5'd9; id_use_rt = 1;
    for (int i = 0; i < 18; i++) tick(1);
    clear_inputs();
    tick(0);
    total++;
    if (stall_cnt !== 4'hf) begin bad++; $display("FAIL sat_hold got=%0d exp=15", stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mdu();
    test_raw();
    test_fwd();
    test_reset_mid_mdu();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
